// File: rtl/bit_pixel_bram_reader.sv
// -----------------------------------------------------------------------------
// bit_pixel_bram_reader
//
// Read side of the rotated bit-pixel frame buffer. When the writer finishes a
// frame (image_number moves away from the last consumed frame), the completed
// buffer half is read out of the left, center and right third BRAMs in raster
// order and streamed as 16-pixel words with ready/valid flow control.
//
// Reads are only launched when a slot is guaranteed in the show-ahead skid
// FIFO (depth rd_latency + 2), so backpressure never drops BRAM data.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   image_number       writer frame counter (4-bit, modular)
//   rd_en/rd_addr      BRAM read strobe and word address
//   rd_third           BRAM select: 0 left, 1 center, 2 right
//   rd_data            BRAM data, valid rd_latency cycles after rd_en
//   pix_out*           output word plus third/col/row/sof/eof tags
//   pix_out_valid/_ready  output handshake
//   bm_idle            high only while idle (writer may use either half)
//   bm_working_buf     buffer half currently being read
//   frame_done         one-cycle pulse after the eof word is accepted
//   overrun            sticky: at least one completed frame was skipped
// -----------------------------------------------------------------------------
module bit_pixel_bram_reader #(
  parameter int third_cols  = 240,
  parameter int center_cols = 304,
  parameter int third_rows  = 480,
  parameter int num_pix     = 16,
  parameter int rd_latency  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  image_number,
  output logic        rd_en,
  output logic [15:0] rd_addr,
  output logic [1:0]  rd_third,
  input  logic [15:0] rd_data,
  output logic [15:0] pix_out,
  output logic        pix_out_valid,
  input  logic        pix_out_ready,
  output logic [1:0]  pix_out_third,
  output logic [4:0]  pix_out_col,
  output logic [8:0]  pix_out_row,
  output logic        pix_out_sof,
  output logic        pix_out_eof,
  output logic        bm_idle,
  output logic        bm_working_buf,
  output logic        frame_done,
  output logic        overrun
);

  localparam int side_wc    = third_cols / num_pix;
  localparam int center_wc  = center_cols / num_pix;
  localparam int fifo_depth = rd_latency + 2;
  localparam int fifo_aw    = $clog2(fifo_depth);
  localparam int cnt_w      = $clog2(fifo_depth + 1);

  localparam logic [15:0] side_base1      = 16'(side_wc * third_rows);
  localparam logic [15:0] center_base1    = 16'(center_wc * third_rows);
  localparam logic [4:0]  side_last_col   = 5'(side_wc - 1);
  localparam logic [4:0]  center_last_col = 5'(center_wc - 1);
  localparam logic [8:0]  last_row        = 9'(third_rows - 1);
  localparam logic [fifo_aw-1:0] last_ptr = fifo_aw'(fifo_depth - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN} state_t;

  typedef struct packed {
    logic [1:0] third;
    logic [4:0] col;
    logic [8:0] row;
    logic       sof;
    logic       eof;
  } tag_t;

  state_t      state_q, state_d;
  logic [3:0]  target_q, target_d;
  logic [3:0]  consumed_q, consumed_d;
  logic        buf_q, buf_d;
  logic [1:0]  third_q, third_d;
  logic [8:0]  row_q, row_d;
  logic [4:0]  col_q, col_d;
  logic [15:0] addr_q, addr_d;
  logic        overrun_q, overrun_d;
  logic        frame_done_q, frame_done_d;

  logic [rd_latency-1:0] v_q;
  tag_t                  tag_q [rd_latency];

  logic [15:0]        fifo_data_q [fifo_depth];
  tag_t               fifo_tag_q  [fifo_depth];
  logic [fifo_aw-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_w-1:0]   cnt_q;

  int         in_flight;
  logic       issue, push, pop;
  logic [4:0] last_col;
  logic [3:0] frame_gap;
  tag_t       tag_cur, head_tag;

  // Reads launched but not yet written into the FIFO.
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < rd_latency; i++) in_flight += int'(v_q[i]);
  end

  // A read is launched only if its word is guaranteed a FIFO slot even when
  // the consumer stalls from now on.
  assign issue = (state_q == ST_READ) && ((in_flight + int'(cnt_q)) < fifo_depth);
  assign push  = v_q[rd_latency-1];
  assign pop   = (cnt_q != '0) && pix_out_ready;

  assign last_col  = (third_q == 2'd1) ? center_last_col : side_last_col;
  assign frame_gap = image_number - consumed_q;
  assign head_tag  = fifo_tag_q[rd_ptr_q];

  always_comb begin
    tag_cur.third = third_q;
    tag_cur.col   = col_q;
    tag_cur.row   = row_q;
    tag_cur.sof   = (third_q == 2'd0) && (row_q == '0) && (col_q == '0);
    tag_cur.eof   = (third_q == 2'd2) && (row_q == last_row) && (col_q == last_col);
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    consumed_d   = consumed_q;
    buf_d        = buf_q;
    third_d      = third_q;
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    overrun_d    = overrun_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (image_number != consumed_q) begin
          // The writer has moved to the other half; read the one it finished.
          target_d = image_number;
          buf_d    = ~image_number[0];
          third_d  = 2'd0;
          row_d    = '0;
          col_d    = '0;
          addr_d   = ~image_number[0] ? side_base1 : 16'd0;
          if (frame_gap > 4'd1) overrun_d = 1'b1;
          state_d  = ST_READ;
        end
      end
      ST_READ: begin
        if (issue) begin
          addr_d = addr_q + 16'd1;
          if (col_q == last_col) begin
            col_d = '0;
            if (row_q == last_row) begin
              row_d = '0;
              // Each third lives in its own BRAM, so the address restarts at
              // that BRAM's base for the selected half.
              case (third_q)
                2'd0: begin
                  third_d = 2'd1;
                  addr_d  = buf_q ? center_base1 : 16'd0;
                end
                2'd1: begin
                  third_d = 2'd2;
                  addr_d  = buf_q ? side_base1 : 16'd0;
                end
                default: state_d = ST_DRAIN;
              endcase
            end else begin
              row_d = row_q + 9'd1;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && head_tag.eof) begin
          consumed_d   = target_q;
          frame_done_d = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      consumed_q   <= '0;
      buf_q        <= 1'b0;
      third_q      <= '0;
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
      v_q          <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      consumed_q   <= consumed_d;
      buf_q        <= buf_d;
      third_q      <= third_d;
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      overrun_q    <= overrun_d;
      frame_done_q <= frame_done_d;
      v_q[0]       <= issue;
      for (int i = 1; i < rd_latency; i++) v_q[i] <= v_q[i-1];
      if (push) wr_ptr_q <= (wr_ptr_q == last_ptr) ? '0 : wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= (rd_ptr_q == last_ptr) ? '0 : rd_ptr_q + 1'b1;
      cnt_q        <= cnt_q + cnt_w'(push) - cnt_w'(pop);
    end
  end

  // NOTE: tag pipeline and FIFO storage carry no reset; the valid bits and
  // the FIFO count decide whether their contents mean anything.
  always_ff @(posedge clk) begin
    tag_q[0] <= tag_cur;
    for (int i = 1; i < rd_latency; i++) tag_q[i] <= tag_q[i-1];
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_data;
      fifo_tag_q[wr_ptr_q]  <= tag_q[rd_latency-1];
    end
  end

  assign rd_en          = issue;
  assign rd_addr        = addr_q;
  assign rd_third       = third_q;
  assign pix_out        = fifo_data_q[rd_ptr_q];
  assign pix_out_valid  = (cnt_q != '0);
  assign pix_out_third  = head_tag.third;
  assign pix_out_col    = head_tag.col;
  assign pix_out_row    = head_tag.row;
  assign pix_out_sof    = head_tag.sof;
  assign pix_out_eof    = head_tag.eof;
  assign bm_idle        = (state_q == ST_IDLE);
  assign bm_working_buf = buf_q;
  assign frame_done     = frame_done_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_bit_pixel_bram_reader.sv
// -----------------------------------------------------------------------------
// Testbench for bit_pixel_bram_reader. A 2-cycle BRAM model answers reads
// with an address/third-dependent pattern; each frame request pushes the full
// expected word stream into a queue, and an independent monitor pops and
// compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_bit_pixel_bram_reader;

  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  third;
    logic [4:0]  col;
    logic [8:0]  row;
    logic        sof;
    logic        eof;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  image_number;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [1:0]  rd_third;
  logic [15:0] rd_data;
  logic [15:0] pix_out;
  logic        pix_out_valid;
  logic        pix_out_ready;
  logic [1:0]  pix_out_third;
  logic [4:0]  pix_out_col;
  logic [8:0]  pix_out_row;
  logic        pix_out_sof;
  logic        pix_out_eof;
  logic        bm_idle;
  logic        bm_working_buf;
  logic        frame_done;
  logic        overrun;

  int   total = 0;
  int   bad = 0;
  int   words_acc = 0;
  int   issued = 0;
  int   accepted = 0;
  int   viol = 0;
  exp_t exp_q[$];
  exp_t mon_act, mon_exp;

  bit_pixel_bram_reader dut (
    .clk            (clk),
    .reset          (reset),
    .image_number   (image_number),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_third       (rd_third),
    .rd_data        (rd_data),
    .pix_out        (pix_out),
    .pix_out_valid  (pix_out_valid),
    .pix_out_ready  (pix_out_ready),
    .pix_out_third  (pix_out_third),
    .pix_out_col    (pix_out_col),
    .pix_out_row    (pix_out_row),
    .pix_out_sof    (pix_out_sof),
    .pix_out_eof    (pix_out_eof),
    .bm_idle        (bm_idle),
    .bm_working_buf (bm_working_buf),
    .frame_done     (frame_done),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] data_fn(input logic [1:0] t, input logic [15:0] a);
    return a ^ {t, 14'h0A5A};
  endfunction

  // BRAM model, two-cycle read latency.
  logic [15:0] bram_s0, bram_s1;
  always @(posedge clk) begin
    bram_s0 <= rd_en ? data_fn(rd_third, rd_addr) : 16'hDEAD;
    bram_s1 <= bram_s0;
  end
  assign rd_data = bram_s1;

  // Outstanding words = reads issued minus words accepted.
  always @(posedge clk) begin
    if (reset) begin
      issued   <= 0;
      accepted <= 0;
    end else begin
      issued   <= issued + int'(rd_en);
      accepted <= accepted + int'(pix_out_valid && pix_out_ready);
    end
  end

  always @(negedge clk) begin
    if (!reset && rd_en && (issued - accepted >= 4)) viol++;
  end

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset && pix_out_valid && pix_out_ready) begin
      mon_act = {pix_out, pix_out_third, pix_out_col, pix_out_row, pix_out_sof, pix_out_eof};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_word: got %h, expected queue empty", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          bad++;
          $display("FAIL word_%0d: got %h expected %h", words_acc, mon_act, mon_exp);
        end
      end
      words_acc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic b);
    int   wc;
    int   base;
    exp_t e;
    for (int t = 0; t < 3; t++) begin
      wc   = (t == 1) ? 19 : 15;
      base = b ? ((t == 1) ? 9120 : 7200) : 0;
      for (int r = 0; r < 480; r++) begin
        for (int c = 0; c < wc; c++) begin
          e.data  = data_fn(2'(t), 16'(base + r * wc + c));
          e.third = 2'(t);
          e.col   = 5'(c);
          e.row   = 9'(r);
          e.sof   = (t == 0) && (r == 0) && (c == 0);
          e.eof   = (t == 2) && (r == 479) && (c == wc - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  task automatic first_read(input logic [15:0] exp_addr);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (rd_en) found = 1'b1;
    end
    check("first_read_seen", 32'(found), 1);
    check("first_read_addr", 32'(rd_addr), 32'(exp_addr));
    check("first_read_third", 32'(rd_third), 0);
  endtask

  task automatic wait_eof(input int budget);
    bit found = 1'b0;
    bit idle_at_eof = 1'b1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (pix_out_valid && pix_out_ready && pix_out_eof) begin
        found       = 1'b1;
        idle_at_eof = bm_idle;
      end
    end
    check("eof_seen", 32'(found), 1);
    check("bm_idle_in_eof_cycle", 32'(idle_at_eof), 0);
    @(negedge clk);
    check("bm_idle_after_eof", 32'(bm_idle), 1);
    check("frame_done_pulse", 32'(frame_done), 1);
    @(negedge clk);
    check("frame_done_one_cycle", 32'(frame_done), 0);
  endtask

  initial begin
    exp_t snap, cur;
    int   diffs;
    int   rd_seen;

    reset         = 1'b1;
    image_number  = 4'd0;
    pix_out_ready = 1'b0;
    repeat (3) tick();
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_valid", 32'(pix_out_valid), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_bm_idle", 32'(bm_idle), 1);
    check("rst_working_buf", 32'(bm_working_buf), 0);
    reset = 1'b0;
    repeat (5) tick();
    check("idle_no_read", 32'(rd_en), 0);
    check("idle_bm_idle", 32'(bm_idle), 1);

    // Frame 1: buffer 0, no backpressure.
    words_acc = 0;
    push_frame(1'b0);
    pix_out_ready = 1'b1;
    image_number  = 4'd1;
    first_read(16'd0);
    check("f1_working_buf", 32'(bm_working_buf), 0);
    check("f1_bm_idle_busy", 32'(bm_idle), 0);
    wait_eof(30000);
    check("f1_words", 32'(words_acc), 23520);
    check("f1_queue_empty", 32'(exp_q.size()), 0);
    check("f1_overrun", 32'(overrun), 0);

    // Frame 2: buffer 1, random 30% ready, then a 100-cycle stall.
    words_acc = 0;
    push_frame(1'b1);
    image_number = 4'd2;
    first_read(16'd7200);
    check("f2_working_buf", 32'(bm_working_buf), 1);
    for (int i = 0; i < 3000; i++) begin
      tick();
      pix_out_ready = ($urandom_range(0, 99) < 30);
    end
    pix_out_ready = 1'b0;
    diffs = 0;
    snap  = '0;
    for (int i = 0; i < 100; i++) begin
      tick();
      cur = {pix_out, pix_out_third, pix_out_col, pix_out_row, pix_out_sof, pix_out_eof};
      if (i == 10) snap = cur;
      if (i > 10 && (cur !== snap || !pix_out_valid)) diffs++;
    end
    check("stall_outputs_stable", 32'(diffs), 0);
    check("stall_outstanding", 32'(issued - accepted), 4);
    pix_out_ready = 1'b1;
    wait_eof(30000);
    check("f2_words", 32'(words_acc), 23520);
    check("f2_queue_empty", 32'(exp_q.size()), 0);
    check("f2_outstanding_limit", 32'(viol), 0);
    check("f2_overrun", 32'(overrun), 0);

    // Frame 3: skipped frame after reset (0 -> 2) reads buffer 1.
    reset        = 1'b1;
    image_number = 4'd0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("f3_overrun_cleared", 32'(overrun), 0);
    words_acc = 0;
    push_frame(1'b1);
    image_number = 4'd2;
    first_read(16'd7200);
    check("f3_overrun_set", 32'(overrun), 1);
    check("f3_working_buf", 32'(bm_working_buf), 1);
    wait_eof(30000);
    check("f3_words", 32'(words_acc), 23520);
    check("f3_queue_empty", 32'(exp_q.size()), 0);
    check("f3_overrun_sticky", 32'(overrun), 1);
    rd_seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      rd_seen += int'(rd_en);
    end
    check("f3_consumed_no_restart", 32'(rd_seen), 0);

    // Frame 4: reset in the middle of the read, then a clean restart.
    words_acc = 0;
    push_frame(1'b0);
    image_number = 4'd3;
    first_read(16'd0);
    for (int i = 0; i < 6000 && words_acc < 5000; i++) tick();
    check("f4_reached_5000", 32'(words_acc >= 5000), 1);
    reset        = 1'b1;
    image_number = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_bm_idle", 32'(bm_idle), 1);
    check("midrst_valid", 32'(pix_out_valid), 0);
    check("midrst_rd_en", 32'(rd_en), 0);
    exp_q.delete();
    tick();
    reset = 1'b0;
    repeat (5) tick();
    check("midrst_idle_no_read", 32'(rd_en), 0);
    words_acc = 0;
    push_frame(1'b0);
    image_number = 4'd1;
    first_read(16'd0);
    for (int i = 0; i < 1000 && words_acc < 300; i++) tick();
    check("restart_words", 32'(words_acc >= 300), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bit_pixel_bram_reader.md
Name: bit_pixel_bram_reader

Overview:
- Read-side counterpart of the rotated bit-pixel BRAM writer.
- When the writer completes a frame (three thirds: left, center, right), this block reads the completed buffer half out of the three third BRAMs in raster order and streams 16-pixel words to the block matcher with ready/valid backpressure.
- Drives bm_idle / bm_working_buf back to the writer so the writer stalls instead of overwriting the buffer half being read.

Parameters:
- third_cols, 240, pixel columns of the left/right thirds
- center_cols, 304, pixel columns of the center third
- third_rows, 480, rows per third
- num_pix, 16, pixels per BRAM word
- rd_latency, 2, BRAM read latency in cycles, from rd_en to rd_data

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- image_number  in  4  writer frame counter; increments when a frame buffer is completed
- rd_en  out  1  BRAM read strobe
- rd_addr  out  16  BRAM word address
- rd_third  out  2  BRAM select: 00 left, 01 center, 10 right
- rd_data  in  16  BRAM data, valid rd_latency cycles after rd_en
- pix_out  out  16  pixel word
- pix_out_valid  out  1  pix_out valid
- pix_out_ready  in  1  consumer accepts the word when valid&ready
- pix_out_third  out  2  third of the current word
- pix_out_col  out  5  word column within the third
- pix_out_row  out  9  row
- pix_out_sof  out  1  first word of the frame (left, row 0, col 0)
- pix_out_eof  out  1  last word of the frame (right, last row, last col)
- bm_idle  out  1  high only in ST_IDLE
- bm_working_buf  out  1  buffer half being read
- frame_done  out  1  one-cycle pulse when a frame has been fully accepted
- overrun  out  1  sticky; set when a frame was skipped

Behaviour:
- Reset values:
  - rd_en, pix_out_valid, frame_done, overrun: 0
  - bm_idle: 1
  - bm_working_buf: 0
  - consumed_number: 0
  - skid FIFO: empty
  - in-flight count: 0
  - all address and counter registers: 0
- Reset mid-frame discards in-flight reads and FIFO contents.
- Geometry:
  - left/right word columns wc = third_cols/num_pix = 15; center word columns = center_cols/num_pix = 19.
  - Buffer-1 base address: 15*480 = 7200 for left/right, 19*480 = 9120 for center. Buffer-0 base is 0.
  - Word address = base + row*wc + col. Raster order maps to a linear increment from base to base + wc*rows - 1.
- States: ST_IDLE, ST_READ, ST_DRAIN.
- ST_IDLE:
  - When image_number != consumed_number: latch target = image_number, bm_working_buf = ~image_number[0] (the completed half), third = 00, row/col/addr at the left base, then go to ST_READ.
  - If (image_number - consumed_number) mod 16 > 1, also set overrun.
- ST_READ:
  - Issue rd_en whenever in_flight + fifo_count < rd_latency + 2. The skid FIFO has depth rd_latency + 2, so data is never dropped.
  - Each issue advances col; at col = wc-1, col wraps to 0 and row increments.
  - At the last row and last col, advance to the next third's base (left -> center -> right) with row = col = 0.
  - After the right third's last address is issued, go to ST_DRAIN.
  - Tag metadata (third, col, row, sof, eof) travels through a rd_latency-deep shift register aligned with rd_data.
- ST_DRAIN:
  - No new reads are issued.
  - When the eof word is accepted: consumed_number <= target, frame_done pulses for one cycle, go to ST_IDLE.
  - bm_idle rises in the cycle after the eof handshake.
- Output:
  - pix_out_valid = FIFO not empty; the FIFO is show-ahead.
  - Outputs hold stable while valid && !ready.
- Simultaneous events:
  - FIFO write and read in the same cycle keep fifo_count unchanged.
  - An image_number change during ST_READ/ST_DRAIN is ignored until ST_IDLE.
- Counter widths:
  - Address arithmetic is 16-bit; the maximum address is 9120 + 9119 = 18239.
  - image_number comparison is 4-bit modular.

Test Plan:
- Reset, then image_number 0 -> 1, pix_out_ready held 1:
  - reads left addr 0..7199, center 0..9119, right 0..7199; 23520 words out.
  - sof on word 0, eof on word 23519; bm_working_buf = 0; frame_done pulses once.
- Second frame, image_number 1 -> 2:
  - bm_working_buf = 1; left addresses 7200..14399, center 9120..18239.
  - First word has col 0, row 0, third 00.
- Random pix_out_ready at 30% duty with BRAM model latency 2:
  - output sequence identical to the stall-free run; no dropped or duplicated words.
  - rd_en never issued with in_flight + fifo_count >= 4.
- Ready held low for 100 cycles mid-frame:
  - at most 4 outstanding words; outputs stable; resumes correctly when ready returns.
- image_number jumps 0 -> 2 while idle:
  - overrun = 1; reads buffer 1 (~2[0]); consumed_number = 2 at the end.
- Reset asserted during ST_READ at word 5000:
  - next cycle bm_idle = 1, pix_out_valid = 0.
  - A new image_number change restarts cleanly at sof.
